mem_fetch_sequencer: RTL and testbench

- Control sequencer for the PC unit and MDR unit of the simplified LC-3 datapath.
- Runs the instruction fetch: MAR<-PC with PC<-PC+1, memory read with a fixed wait-state count, MDR<-M, IR<-MDR.
- After decode, serves load, store and PC-redirect requests from the execute logic.
- Owns every LD_*/Gate*/memory strobe for PC, MAR, MDR and IR. No other block drives them.

---
 rtl/mem_fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mem_fetch_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_fetch_sequencer.sv
// mem_fetch_sequencer
//   Moore control sequencer for the LC-3 PC/MAR/MDR/IR path. It runs the
//   instruction fetch (MAR<-PC with PC<-PC+1, a timed memory read, MDR<-M,
//   IR<-MDR). After decode it serves load, store and PC-redirect requests.
//   Every output is decoded from the registered state, the wait counter and
//   the held redirect select.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Run          in   starts fetching when high in IDLE
//   Halt         in   sampled in DECODE; returns the machine to IDLE
//   Ex_Op[1:0]   in   request sampled in DECODE: 00 fetch, 01 load, 10 store, 11 redirect
//   Ex_PCsel[1:0] in  PCMUX select for a redirect (01 bus, 10 addrmux)
//   LD_MAR/LD_MDR/LD_PC/LD_IR  out  register load strobes
//   PCMUX_select[1:0] out  00 PC+1, 01 bus, 10 addrmux
//   GatePC/GateMDR     out  bus drivers
//   MIO_EN       out  MDR input select (1 memory, 0 bus)
//   Mem_OE/Mem_WE out  memory read / write strobes
//   IR_Valid     out  one-cycle pulse in DECODE
//   Busy         out  high outside IDLE
module mem_fetch_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Halt,
  input  logic [1:0] Ex_Op,
  input  logic [1:0] Ex_PCsel,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_PC,
  output logic       LD_IR,
  output logic [1:0] PCMUX_select,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       IR_Valid,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_MAR,
    S_F_RD,
    S_F_IR,
    S_DECODE,
    S_LD_RD,
    S_ST_WR,
    S_REDIR
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [1:0] r_pcsel;
  logic [1:0] w_pcsel_next;
  logic       w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 4'd0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pcsel <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pcsel <= w_pcsel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pcsel_next = r_pcsel;
    case (r_state)
      S_IDLE:   if (Run) w_state_next = S_F_MAR;
      S_F_MAR: begin
        w_state_next = S_F_RD;
        w_cnt_next   = LP_CNT_INIT;
      end
      // Counter runs MEM_WAIT-1 down to 0, so each access lasts MEM_WAIT
      // cycles; it holds at 0 rather than wrapping.
      S_F_RD, S_LD_RD, S_ST_WR: begin
        if (w_cnt_zero) begin
          w_state_next = (r_state == S_F_RD) ? S_F_IR : S_F_MAR;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_F_IR:   w_state_next = S_DECODE;
      S_DECODE: begin
        w_pcsel_next = Ex_PCsel;
        if (Halt) begin
          w_state_next = S_IDLE;
        end else begin
          case (Ex_Op)
            2'b01: begin
              w_state_next = S_LD_RD;
              w_cnt_next   = LP_CNT_INIT;
            end
            2'b10: begin
              w_state_next = S_ST_WR;
              w_cnt_next   = LP_CNT_INIT;
            end
            2'b11:   w_state_next = S_REDIR;
            default: w_state_next = S_F_MAR;
          endcase
        end
      end
      S_REDIR:  w_state_next = S_F_MAR;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    LD_MAR       = 1'b0;
    LD_MDR       = 1'b0;
    LD_PC        = 1'b0;
    LD_IR        = 1'b0;
    PCMUX_select = 2'b00;
    GatePC       = 1'b0;
    GateMDR      = 1'b0;
    MIO_EN       = 1'b0;
    Mem_OE       = 1'b0;
    Mem_WE       = 1'b0;
    IR_Valid     = 1'b0;
    Busy         = (r_state != S_IDLE);
    case (r_state)
      S_F_MAR: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_F_RD, S_LD_RD: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = w_cnt_zero;
      end
      S_F_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: IR_Valid = 1'b1;
      S_ST_WR:  Mem_WE   = 1'b1;
      S_REDIR: begin
        LD_PC = 1'b1;
        // Only bus and addrmux are real redirect sources; anything else
        // falls back to the PC+1 path.
        if ((r_pcsel == 2'b01) || (r_pcsel == 2'b10)) begin
          PCMUX_select = r_pcsel;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// tb_mem_fetch_sequencer
//   Directed bench for mem_fetch_sequencer with MEM_WAIT = 2. A small PC/MAR/
//   MDR/IR datapath and memory are modelled here so that register contents
//   can be checked against hand-computed values. Outputs are sampled on the
//   falling clock edge.
module tb_mem_fetch_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       Halt;
  logic [1:0] Ex_Op;
  logic [1:0] Ex_PCsel;
  logic       LD_MAR, LD_MDR, LD_PC, LD_IR;
  logic [1:0] PCMUX_select;
  logic       GatePC, GateMDR, MIO_EN, Mem_OE, Mem_WE, IR_Valid, Busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_fetch_sequencer #(.MEM_WAIT(2)) u_dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .Halt         (Halt),
    .Ex_Op        (Ex_Op),
    .Ex_PCsel     (Ex_PCsel),
    .LD_MAR       (LD_MAR),
    .LD_MDR       (LD_MDR),
    .LD_PC        (LD_PC),
    .LD_IR        (LD_IR),
    .PCMUX_select (PCMUX_select),
    .GatePC       (GatePC),
    .GateMDR      (GateMDR),
    .MIO_EN       (MIO_EN),
    .Mem_OE       (Mem_OE),
    .Mem_WE       (Mem_WE),
    .IR_Valid     (IR_Valid),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output vector: LD_MAR LD_MDR LD_PC LD_IR PCMUX[1:0] GatePC GateMDR
  //                MIO_EN Mem_OE Mem_WE IR_Valid Busy
  logic [12:0] w_outs;
  assign w_outs = {LD_MAR, LD_MDR, LD_PC, LD_IR, PCMUX_select, GatePC, GateMDR,
                   MIO_EN, Mem_OE, Mem_WE, IR_Valid, Busy};

  localparam logic [12:0] EXP_IDLE  = 13'b0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] EXP_FMAR  = 13'b1_0_1_0_00_1_0_0_0_0_0_1;
  localparam logic [12:0] EXP_RD    = 13'b0_0_0_0_00_0_0_1_1_0_0_1;
  localparam logic [12:0] EXP_RDL   = 13'b0_1_0_0_00_0_0_1_1_0_0_1;
  localparam logic [12:0] EXP_FIR   = 13'b0_0_0_1_00_0_1_0_0_0_0_1;
  localparam logic [12:0] EXP_DEC   = 13'b0_0_0_0_00_0_0_0_0_0_1_1;
  localparam logic [12:0] EXP_WR    = 13'b0_0_0_0_00_0_0_0_0_1_0_1;
  localparam logic [12:0] EXP_RDR10 = 13'b0_0_1_0_10_0_0_0_0_0_0_1;

  // Datapath model driven by the sequencer strobes.
  logic [15:0] pc, mar, mdr, ir, addrmux, bus;
  logic [15:0] mem [0:255];

  assign bus = GatePC ? pc : (GateMDR ? mdr : 16'h0000);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc <= 16'h3000;
    end else if (LD_PC) begin
      case (PCMUX_select)
        2'b01:   pc <= bus;
        2'b10:   pc <= addrmux;
        default: pc <= pc + 16'd1;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (LD_MAR) mar <= bus;
    if (LD_MDR) mdr <= MIO_EN ? mem[mar[7:0]] : bus;
    if (LD_IR)  ir  <= bus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe exclusivity holds every cycle.
  always @(negedge Clk) begin
    check("oe_we_excl", 32'(Mem_OE & Mem_WE), 32'd0);
    check("mdr_ir_excl", 32'(LD_MDR & LD_IR), 32'd0);
  end

  // From the F_MAR cycle (counted as 1) step until IR_Valid, with a bound.
  task automatic fetch_to_decode(input string tag);
    int unsigned n  = 1;
    int unsigned oe = 0;
    while (!IR_Valid && n < 20) begin
      @(negedge Clk);
      n++;
      if (Mem_OE) oe++;
    end
    check({tag, "_lat"}, 32'(n), 32'd5);
    check({tag, "_oe"}, 32'(oe), 32'd2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h00] = 16'h2A5C;
    mem[8'h50] = 16'h1234;
    mem[8'h51] = 16'hBEEF;
    Reset = 1'b0; Run = 1'b0; Halt = 1'b0;
    Ex_Op = 2'b00; Ex_PCsel = 2'b00; addrmux = 16'h4050;

    repeat (3) begin
      @(negedge Clk);
      check("reset_outs", 32'(w_outs), 32'(EXP_IDLE));
    end
    Reset = 1'b1; Run = 1'b1;

    // First fetch, stepped explicitly.
    @(negedge Clk); check("f1_fmar", 32'(w_outs), 32'(EXP_FMAR));
    check("f1_pc_pre", 32'(pc), 32'h3000);
    Run = 1'b0;
    @(negedge Clk); check("f1_rd1", 32'(w_outs), 32'(EXP_RD));
    check("f1_mar", 32'(mar), 32'h3000);
    check("f1_pc", 32'(pc), 32'h3001);
    @(negedge Clk); check("f1_rd2", 32'(w_outs), 32'(EXP_RDL));
    @(negedge Clk); check("f1_ir", 32'(w_outs), 32'(EXP_FIR));
    @(negedge Clk); check("f1_dec", 32'(w_outs), 32'(EXP_DEC));
    check("f1_irval", 32'(ir), 32'h2A5C);

    // Load (MAR still 0x3000).
    Ex_Op = 2'b01;
    @(negedge Clk); check("ld_rd1", 32'(w_outs), 32'(EXP_RD));
    Ex_Op = 2'b00;
    @(negedge Clk); check("ld_rd2", 32'(w_outs), 32'(EXP_RDL));
    @(negedge Clk); check("ld_fmar", 32'(w_outs), 32'(EXP_FMAR));
    check("ld_pc_once", 32'(pc), 32'h3001);
    check("ld_mdr", 32'(mdr), 32'h2A5C);
    fetch_to_decode("f2");
    check("f2_pc", 32'(pc), 32'h3002);
    check("f2_irval", 32'(ir), 32'hA001);

    // Store.
    Ex_Op = 2'b10;
    @(negedge Clk); check("st_wr1", 32'(w_outs), 32'(EXP_WR));
    Ex_Op = 2'b00;
    @(negedge Clk); check("st_wr2", 32'(w_outs), 32'(EXP_WR));
    @(negedge Clk); check("st_fmar", 32'(w_outs), 32'(EXP_FMAR));
    check("st_pc", 32'(pc), 32'h3002);
    fetch_to_decode("f3");
    check("f3_pc", 32'(pc), 32'h3003);

    // Redirect via addrmux; the live select changes after DECODE.
    Ex_Op = 2'b11; Ex_PCsel = 2'b10;
    @(negedge Clk); check("rdr_outs", 32'(w_outs), 32'(EXP_RDR10));
    Ex_Op = 2'b00; Ex_PCsel = 2'b01;
    @(negedge Clk); check("rdr_fmar", 32'(w_outs), 32'(EXP_FMAR));
    check("rdr_pc", 32'(pc), 32'h4050);
    fetch_to_decode("f4");
    check("f4_mar", 32'(mar), 32'h4050);
    check("f4_pc", 32'(pc), 32'h4051);
    check("f4_irval", 32'(ir), 32'h1234);

    // Halt wins over a load request.
    Halt = 1'b1; Ex_Op = 2'b01;
    @(negedge Clk); check("halt_idle", 32'(w_outs), 32'(EXP_IDLE));
    Halt = 1'b0; Ex_Op = 2'b00;
    @(negedge Clk); check("halt_stay", 32'(w_outs), 32'(EXP_IDLE));
    Run = 1'b1;
    @(negedge Clk); check("resume_fmar", 32'(w_outs), 32'(EXP_FMAR));
    check("resume_pc", 32'(pc), 32'h4051);
    Run = 1'b0;
    @(negedge Clk); check("rst_rd1", 32'(w_outs), 32'(EXP_RD));

    // Asynchronous reset in the second F_RD cycle.
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1; check("rst_mid_outs", 32'(w_outs), 32'(EXP_IDLE));
    @(negedge Clk); check("rst_hold_outs", 32'(w_outs), 32'(EXP_IDLE));
    @(negedge Clk); check("rst_mdr_kept", 32'(mdr), 32'h1234);
    check("rst_pc", 32'(pc), 32'h3000);
    Reset = 1'b1;
    @(negedge Clk); check("post_rst_idle", 32'(w_outs), 32'(EXP_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
